stopwatch_ctrl: RTL

Run/pause/lap/clear controller for the 50 MHz stopwatch.
- Turns two push-buttons into a Moore FSM.
- Generates the 10 ms count-enable pulse for the BCD time counters (t_ms0..t_m1) and the digit-scan tick for the 7-segment scanner.
- Sits between the board buttons and the counter/display datapath; it sequences that datapath and owns no time digits itself.

---
 rtl/stopwatch_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear FSM with 10 ms count-enable and digit-scan prescalers.
// Optional feature: define SW_LAP_EN to build the LAP state (display hold while running).
module stopwatch_ctrl #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 100,
    parameter int SCAN_HZ = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_ss,
    input  logic       btn_lc,
    input  logic       cnt_full,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       disp_hold,
    output logic       scan_tick,
    output logic       run_led,
    output logic [1:0] state_o
);
    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int SDIV = CLK_HZ / SCAN_HZ;
    localparam int DW   = $clog2(DIV);
    localparam int SW   = $clog2(SDIV);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      ss_sync_q, lc_sync_q;
    logic            ss_prev_q, lc_prev_q;
    logic [DW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]   scan_cnt_q;
    logic            cnt_en_q, cnt_en_d, cnt_clr_q, cnt_clr_d;
    logic            ss_edge, lc_edge, running, tick;

    assign ss_edge = ss_sync_q[1] & ~ss_prev_q;
    assign lc_edge = lc_sync_q[1] & ~lc_prev_q;
`ifdef SW_LAP_EN
    assign running   = (state_q == RUN) || (state_q == LAP);
    assign disp_hold = (state_q == LAP);
`else
    assign running   = (state_q == RUN);
    assign disp_hold = 1'b0;
`endif
    assign tick      = running && (tick_cnt_q == DW'(DIV - 1));
    assign cnt_en    = cnt_en_q;
    assign cnt_clr   = cnt_clr_q;
    assign run_led   = running;
    assign state_o   = state_q;
    assign scan_tick = (scan_cnt_q == SW'(SDIV - 1));

    // Button synchronizers and previous-value registers for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync_q <= '0;
            lc_sync_q <= '0;
            ss_prev_q <= 1'b0;
            lc_prev_q <= 1'b0;
        end else begin
            ss_sync_q <= {ss_sync_q[0], btn_ss};
            lc_sync_q <= {lc_sync_q[0], btn_lc};
            ss_prev_q <= ss_sync_q[1];
            lc_prev_q <= lc_sync_q[1];
        end
    end

    // Next state, prescaler update and pulse generation; overflow beats buttons, ss beats lc
    always_comb begin
        state_d    = state_q;
        cnt_clr_d  = 1'b0;
        cnt_en_d   = tick & ~cnt_full;
        tick_cnt_d = (state_q == IDLE) ? '0 :
                     running ? (tick ? '0 : tick_cnt_q + 1'b1) : tick_cnt_q;
        case (state_q)
            IDLE: begin
                if (ss_edge) state_d = RUN;
                else if (lc_edge) cnt_clr_d = 1'b1;
            end
            RUN: begin
                if (tick && cnt_full) state_d = PAUSE;
                else if (ss_edge) state_d = PAUSE;
`ifdef SW_LAP_EN
                else if (lc_edge) state_d = LAP;
`endif
            end
            PAUSE: begin
                if (ss_edge) state_d = RUN;
                else if (lc_edge) begin
                    state_d   = IDLE;
                    cnt_clr_d = 1'b1;
                end
            end
`ifdef SW_LAP_EN
            LAP: begin
                if (tick && cnt_full) state_d = PAUSE;
                else if (ss_edge) state_d = PAUSE;
                else if (lc_edge) state_d = RUN;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State, prescalers and registered one-cycle pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            scan_cnt_q <= '0;
            cnt_en_q   <= 1'b0;
            cnt_clr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            scan_cnt_q <= scan_tick ? '0 : scan_cnt_q + 1'b1;
            cnt_en_q   <= cnt_en_d;
            cnt_clr_q  <= cnt_clr_d;
        end
    end
endmodule
